// File: rtl/fb_pkg.sv
// Framebuffer geometry and pixel/address types shared by the fill and scan-out blocks.
package fb_pkg;

  localparam int unsigned FB_W     = 280;
  localparam int unsigned FB_H     = 192;
  localparam int unsigned FB_WORDS = FB_W * FB_H;

  // {R[23:16], G[15:8], B[7:0]}
  typedef logic [23:0] pixel_t;
  typedef logic [15:0] fb_addr_t;

endpackage

// File: rtl/fb_rect_clip.sv
// Combinational rectangle clipping: clipped extents, start address and empty detection.
module fb_rect_clip #(
  parameter int unsigned FB_W = fb_pkg::FB_W,
  parameter int unsigned FB_H = fb_pkg::FB_H
) (
  input  logic [8:0]       x,
  input  logic [7:0]       y,
  input  logic [8:0]       w,
  input  logic [7:0]       h,
  output logic [8:0]       cw,
  output logic [7:0]       ch,
  output fb_pkg::fb_addr_t start_adr,
  output logic             empty
);
  import fb_pkg::*;

  localparam logic [9:0] FbW10 = 10'(FB_W);
  localparam logic [9:0] FbH10 = 10'(FB_H);

  logic [9:0] x10, y10, w10, h10;
  logic [9:0] room_x, room_y;
  logic       x_out, y_out;

  // Clip against the right and bottom edges; 10-bit math so the remaining room never wraps.
  always_comb begin
    x10    = {1'b0, x};
    y10    = {2'b00, y};
    w10    = {1'b0, w};
    h10    = {2'b00, h};
    x_out  = (x10 >= FbW10);
    y_out  = (y10 >= FbH10);
    room_x = x_out ? 10'd0 : (FbW10 - x10);
    room_y = y_out ? 10'd0 : (FbH10 - y10);
    empty  = x_out || y_out || (w == '0) || (h == '0);
    // The min never exceeds w or h, so narrowing back is lossless.
    cw     = (w10 < room_x) ? w : room_x[8:0];
    ch     = (h10 < room_y) ? h : room_y[7:0];
    // Only meaningful when not empty; the single multiply lives here, never in FILL.
    start_adr = fb_addr_t'(y) * fb_addr_t'(FB_W) + fb_addr_t'(x);
  end

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: accepts a command, clips it, then writes one pixel per cycle.
module fb_rect_fill #(
  parameter int unsigned FB_W = fb_pkg::FB_W,
  parameter int unsigned FB_H = fb_pkg::FB_H
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [8:0]  cmd_x,
  input  logic [7:0]  cmd_y,
  input  logic [8:0]  cmd_w,
  input  logic [7:0]  cmd_h,
  input  logic [23:0] cmd_color,
  output logic [15:0] fb_wadr,
  output logic [23:0] fb_d,
  output logic        fb_we,
  output logic        busy,
  output logic        done
);
  import fb_pkg::*;

  typedef enum logic [1:0] {StIdle, StClip, StFill} state_e;

  state_e     state_q;
  logic [8:0] x_q, w_q, cw_q, col_q;
  logic [7:0] y_q, h_q, ch_q, row_q;
  pixel_t     color_q;
  fb_addr_t   row_base_q;

  logic [8:0] clip_cw;
  logic [7:0] clip_ch;
  fb_addr_t   clip_start;
  logic       clip_empty;
  logic       last_col, last_row;

  fb_rect_clip #(
    .FB_W(FB_W),
    .FB_H(FB_H)
  ) u_clip (
    .x        (x_q),
    .y        (y_q),
    .w        (w_q),
    .h        (h_q),
    .cw       (clip_cw),
    .ch       (clip_ch),
    .start_adr(clip_start),
    .empty    (clip_empty)
  );

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign last_col  = (col_q == cw_q - 9'd1);
  assign last_row  = (row_q == ch_q - 8'd1);

  // Control FSM with registered write port and done pulse.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= StIdle;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      cw_q       <= '0;
      ch_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      fb_wadr    <= '0;
      fb_d       <= '0;
      fb_we      <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            x_q     <= cmd_x;
            y_q     <= cmd_y;
            w_q     <= cmd_w;
            h_q     <= cmd_h;
            color_q <= cmd_color;
            state_q <= StClip;
          end
        end
        StClip: begin
          if (clip_empty) begin
            done    <= 1'b1;
            state_q <= StIdle;
          end else begin
            cw_q       <= clip_cw;
            ch_q       <= clip_ch;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= clip_start;
            fb_wadr    <= clip_start;
            fb_d       <= color_q;
            fb_we      <= 1'b1;
            state_q    <= StFill;
          end
        end
        StFill: begin
          if (last_col) begin
            if (last_row) begin
              fb_we   <= 1'b0;
              done    <= 1'b1;
              state_q <= StIdle;
            end else begin
              col_q      <= '0;
              row_q      <= row_q + 8'd1;
              row_base_q <= row_base_q + fb_addr_t'(FB_W);
              fb_wadr    <= row_base_q + fb_addr_t'(FB_W);
            end
          end else begin
            col_q   <= col_q + 9'd1;
            fb_wadr <= fb_wadr + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
